// File: rtl/panel_load_sequencer_pkg.sv
// Shared types for the front-panel image loader: sequencer states, the 12-bit
// PDP-8 word type and the saturating word counter helper.
package panel_load_sequencer_pkg;

   typedef logic [11:0] word;

   typedef enum logic [3:0] {
      ACCEPT,
      ADDR_SETUP,
      ADDR_PRESS,
      ADDR_RELEASE,
      DATA_SETUP,
      DATA_PRESS,
      DATA_RELEASE,
      PC_SETUP,
      PC_PRESS,
      PC_RELEASE,
      RUN_ARM,
      RUN_WAIT_HI,
      RUN_WAIT_LO,
      DONE
   } seqState_t;

   localparam word         DEFAULT_START_PC = 12'o0200;
   localparam logic [12:0] MAX_WORD_COUNT   = 13'd4096;
   localparam logic [12:0] RUN_SWITCH       = 13'h1000;

   // The count stops at a full 4K image; extra words still deposit but are not counted.
   function automatic logic [12:0] satIncrement(input logic [12:0] count);
      return (count == MAX_WORD_COUNT) ? count : count + 13'd1;
   endfunction

endpackage

// File: rtl/panel_load_sequencer_panel_phase_timer.sv
// Down-counter that times one front-panel phase; reloads on every state entry
// and flags the last cycle of the phase.
module panel_phase_timer #(
   parameter int HOLD_CYCLES = 10
)(
   input  logic clock,
   input  logic reset,
   input  logic i_load,
   output logic o_expired
);

   localparam int            CW     = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= RELOAD;
      end else if (i_load) begin
         r_count <= RELOAD;
      end else if (r_count != '0) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign o_expired = (r_count == '0);

endmodule

// File: rtl/panel_load_sequencer.sv
// Drives the PDP-8 front panel switches and buttons to deposit an image word by
// word, loads the start PC, raises RUN and reports when the program halts.
module panel_load_sequencer
   import panel_load_sequencer_pkg::*;
#(
   parameter int  HOLD_CYCLES = 10,
   parameter word START_PC    = DEFAULT_START_PC
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        word_valid,
   output logic        word_ready,
   input  logic [11:0] word_addr,
   input  logic [11:0] word_data,
   input  logic        word_last,
   output logic [12:0] sw,
   output logic        load_pc_btn,
   output logic        deposit_btn,
   input  logic        run_led,
   output logic        busy,
   output logic        done,
   output logic [12:0] word_count
);

   seqState_t   r_state;
   seqState_t   w_nextState;
   word         r_addr;
   word         r_data;
   logic        r_last;
   logic        r_live;
   logic [12:0] r_wordCount;
   logic        w_handshake;
   logic        w_expired;
   logic        w_timerLoad;

   // r_live keeps word_ready low for the cycle in which reset is still being sampled.
   assign w_handshake = word_valid && r_live && (r_state == ACCEPT);
   assign w_timerLoad = (w_nextState != r_state);

   panel_phase_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_phaseTimer (
      .clock     (clock),
      .reset     (reset),
      .i_load    (w_timerLoad),
      .o_expired (w_expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ACCEPT;
         r_addr      <= '0;
         r_data      <= '0;
         r_last      <= 1'b0;
         r_live      <= 1'b0;
         r_wordCount <= '0;
      end else begin
         r_state <= w_nextState;
         r_live  <= 1'b1;
         if (w_handshake) begin
            r_addr <= word_addr;
            r_data <= word_data;
            r_last <= word_last;
         end
         if (r_state == DATA_RELEASE && w_expired) begin
            r_wordCount <= satIncrement(r_wordCount);
         end
      end
   end

   // Each button is only pressed while its switch value has been stable for a full phase.
   always_comb begin
      w_nextState = r_state;
      sw          = '0;
      load_pc_btn = 1'b0;
      deposit_btn = 1'b0;
      word_ready  = 1'b0;
      done        = 1'b0;
      case (r_state)
         ACCEPT: begin
            word_ready = r_live;
            if (w_handshake) w_nextState = ADDR_SETUP;
         end
         ADDR_SETUP: begin
            sw = {1'b0, r_addr};
            if (w_expired) w_nextState = ADDR_PRESS;
         end
         ADDR_PRESS: begin
            sw          = {1'b0, r_addr};
            load_pc_btn = 1'b1;
            if (w_expired) w_nextState = ADDR_RELEASE;
         end
         ADDR_RELEASE: begin
            sw = {1'b0, r_addr};
            if (w_expired) w_nextState = DATA_SETUP;
         end
         DATA_SETUP: begin
            sw = {1'b0, r_data};
            if (w_expired) w_nextState = DATA_PRESS;
         end
         DATA_PRESS: begin
            sw          = {1'b0, r_data};
            deposit_btn = 1'b1;
            if (w_expired) w_nextState = DATA_RELEASE;
         end
         DATA_RELEASE: begin
            sw = {1'b0, r_data};
            if (w_expired) w_nextState = r_last ? PC_SETUP : ACCEPT;
         end
         PC_SETUP: begin
            sw = {1'b0, START_PC};
            if (w_expired) w_nextState = PC_PRESS;
         end
         PC_PRESS: begin
            sw          = {1'b0, START_PC};
            load_pc_btn = 1'b1;
            if (w_expired) w_nextState = PC_RELEASE;
         end
         PC_RELEASE: begin
            sw = {1'b0, START_PC};
            if (w_expired) w_nextState = RUN_ARM;
         end
         RUN_ARM: begin
            sw = RUN_SWITCH;
            if (w_expired) w_nextState = RUN_WAIT_HI;
         end
         RUN_WAIT_HI: begin
            sw = RUN_SWITCH;
            if (run_led) w_nextState = RUN_WAIT_LO;
         end
         RUN_WAIT_LO: begin
            sw = RUN_SWITCH;
            if (!run_led) w_nextState = DONE;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            w_nextState = ACCEPT;
         end
      endcase
   end

   assign busy       = !(((r_state == ACCEPT) && (r_wordCount == '0)) || (r_state == DONE));
   assign word_count = r_wordCount;

endmodule

// File: tb/tb_panel_load_sequencer.sv
// Bench for panel_load_sequencer: two instances (HOLD_CYCLES 10 and 1) driven with
// random images and checked cycle by cycle against a timeline model of the panel.
module tb_panel_load_sequencer;

   localparam logic [11:0] START_PC = 12'o0200;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic        reset     [2];
   logic        wordValid [2];
   logic        wordReady [2];
   logic [11:0] wordAddr  [2];
   logic [11:0] wordData  [2];
   logic        wordLast  [2];
   logic [12:0] sw        [2];
   logic        loadPc    [2];
   logic        deposit   [2];
   logic        runLed    [2];
   logic        busy      [2];
   logic        done      [2];
   logic [12:0] wordCount [2];

   logic [11:0] imgAddr [$];
   logic [11:0] imgData [$];

   panel_load_sequencer #(.HOLD_CYCLES(10), .START_PC(START_PC)) dut0 (
      .clock(clock), .reset(reset[0]), .word_valid(wordValid[0]), .word_ready(wordReady[0]),
      .word_addr(wordAddr[0]), .word_data(wordData[0]), .word_last(wordLast[0]), .sw(sw[0]),
      .load_pc_btn(loadPc[0]), .deposit_btn(deposit[0]), .run_led(runLed[0]), .busy(busy[0]),
      .done(done[0]), .word_count(wordCount[0])
   );

   panel_load_sequencer #(.HOLD_CYCLES(1), .START_PC(START_PC)) dut1 (
      .clock(clock), .reset(reset[1]), .word_valid(wordValid[1]), .word_ready(wordReady[1]),
      .word_addr(wordAddr[1]), .word_data(wordData[1]), .word_last(wordLast[1]), .sw(sw[1]),
      .load_pc_btn(loadPc[1]), .deposit_btn(deposit[1]), .run_led(runLed[1]), .busy(busy[1]),
      .done(done[1]), .word_count(wordCount[1])
   );

   // Output vector layout: {sw, load_pc_btn, deposit_btn, word_ready, busy, done, word_count}
   function automatic logic [30:0] pack(input logic [12:0] s, input logic lp, input logic dp,
                                        input logic rdy, input logic bsy, input logic dn,
                                        input logic [12:0] cnt);
      return {s, lp, dp, rdy, bsy, dn, cnt};
   endfunction

   function automatic logic [30:0] obsVec(input int d);
      return pack(sw[d], loadPc[d], deposit[d], wordReady[d], busy[d], done[d], wordCount[d]);
   endfunction

   function automatic int satInc(input int c);
      return (c >= 4096) ? 4096 : c + 1;
   endfunction

   task automatic resetDut(input int d);
      @(negedge clock);
      reset[d] = 1'b1; wordValid[d] = 1'b0; runLed[d] = 1'b0;
      repeat (3) @(negedge clock);
      reset[d] = 1'b0;
      @(negedge clock);
   endtask

   // Drives imgAddr/imgData as one image and follows the per-word panel timeline.
   task automatic applyStimulus(input int d, input int h, input int gapMin, input int gapMax,
                                input bit runEarly, input string tag);
      int n = imgAddr.size();
      int expCount = 0;
      int prevHs = -1;
      int gap, wHi, wLo, p;
      bit last;
      logic [12:0] eSw;
      logic eLp, eDp;
      logic [30:0] exp, obs;
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         gap = int'($urandom_range(gapMax, gapMin));
         for (int g = 0; g <= gap; g++) begin
            @(negedge clock);
            exp = pack(13'd0, 1'b0, 1'b0, 1'b1, expCount != 0, 1'b0, 13'(expCount));
            obs = obsVec(d);
            compared++;
            if (obs !== exp) begin
               mismatched++;
               $display("[TB] FAIL %s/idle word %0d: got %h expected %h", tag, i, obs, exp);
            end
            wordValid[d] = (g == gap);
            wordAddr[d]  = (g == gap) ? imgAddr[i] : 12'($urandom);
            wordData[d]  = (g == gap) ? imgData[i] : 12'($urandom);
            wordLast[d]  = last;
         end
         if (prevHs >= 0 && gap == 0) begin
            compared++;
            if (cyc - prevHs != 6 * h + 1) begin
               mismatched++;
               $display("[TB] FAIL %s/spacing word %0d: got %0d expected %0d", tag, i, cyc - prevHs, 6 * h + 1);
            end
         end
         prevHs = cyc;
         for (int k = 1; k <= (last ? 10 * h : 6 * h); k++) begin
            @(negedge clock);
            p = (k - 1) / h;
            if (k == 6 * h + 1) expCount = satInc(expCount);
            eLp = 1'b0; eDp = 1'b0;
            if (p < 3) begin
               eSw = {1'b0, imgAddr[i]}; eLp = (p == 1);
            end else if (p < 6) begin
               eSw = {1'b0, imgData[i]}; eDp = (p == 4);
            end else if (p < 9) begin
               eSw = {1'b0, START_PC};   eLp = (p == 7);
            end else begin
               eSw = 13'h1000;
            end
            exp = pack(eSw, eLp, eDp, 1'b0, 1'b1, 1'b0, 13'(expCount));
            obs = obsVec(d);
            compared++;
            if (obs !== exp) begin
               mismatched++;
               $display("[TB] FAIL %s/phase word %0d k=%0d: got %h expected %h", tag, i, k, obs, exp);
            end
            wordValid[d] = 1'($urandom_range(1, 0));
            wordAddr[d]  = 12'($urandom);
            wordData[d]  = 12'($urandom);
            wordLast[d]  = 1'($urandom_range(1, 0));
            runLed[d]    = runEarly && (k == 10 * h);
         end
         if (!last) expCount = satInc(expCount);
      end
      wHi = runEarly ? -1 : int'($urandom_range(4, 0));
      for (int w = 0; w <= wHi; w++) begin
         @(negedge clock);
         exp = pack(13'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'(expCount));
         obs = obsVec(d);
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s/wait_hi: got %h expected %h", tag, obs, exp);
         end
         runLed[d] = (w == wHi);
      end
      wLo = int'($urandom_range(4, runEarly ? 1 : 0));
      for (int w = 0; w <= wLo; w++) begin
         @(negedge clock);
         exp = pack(13'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'(expCount));
         obs = obsVec(d);
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s/wait_lo: got %h expected %h", tag, obs, exp);
         end
         runLed[d] = (w != wLo);
      end
      for (int w = 0; w < 3; w++) begin
         @(negedge clock);
         exp = pack(13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'(expCount));
         obs = obsVec(d);
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s/done: got %h expected %h", tag, obs, exp);
         end
         wordValid[d] = 1'($urandom_range(1, 0));
         runLed[d]    = 1'($urandom_range(1, 0));
      end
      wordValid[d] = 1'b0;
      runLed[d]    = 1'b0;
   endtask

   task automatic fillRandom(input int n);
      imgAddr.delete(); imgData.delete();
      for (int i = 0; i < n; i++) begin
         imgAddr.push_back(12'($urandom));
         imgData.push_back(12'($urandom));
      end
   endtask

   task automatic test_reset(input int d);
      logic [30:0] obs;
      @(negedge clock);
      reset[d] = 1'b1; wordValid[d] = 1'b1; runLed[d] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         obs = obsVec(d);
         compared++;
         if (obs !== 31'd0) begin
            mismatched++;
            $display("[TB] FAIL reset%0d/held cycle %0d: got %h expected 0", d, i, obs);
         end
      end
      reset[d] = 1'b0; wordValid[d] = 1'b0;
      @(negedge clock);
      obs = obsVec(d);
      compared++;
      if (obs !== pack(13'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd0)) begin
         mismatched++;
         $display("[TB] FAIL reset%0d/release: got %h expected ready only", d, obs);
      end
   endtask

   task automatic test_single_word;
      resetDut(0);
      imgAddr = {12'o0200}; imgData = {12'o7402};
      applyStimulus(0, 10, 0, 0, 1'b0, "single");
   endtask

   task automatic test_back_to_back;
      resetDut(0);
      imgAddr = {12'o0200, 12'o0201, 12'o0202};
      imgData = {12'o7200, 12'o1000, 12'o7402};
      applyStimulus(0, 10, 0, 0, 1'b1, "b2b");
   endtask

   task automatic test_reset_mid_press;
      logic [30:0] obs, exp;
      resetDut(0);
      @(negedge clock);
      wordValid[0] = 1'b1; wordAddr[0] = 12'o0300; wordData[0] = 12'o1234; wordLast[0] = 1'b0;
      for (int k = 1; k <= 41; k++) begin
         @(negedge clock);
         wordValid[0] = 1'b0;
      end
      exp = pack({1'b0, 12'o1234}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 13'd0);
      obs = obsVec(0);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL midpress/pressing: got %h expected %h", obs, exp);
      end
      reset[0] = 1'b1;
      @(negedge clock);
      obs = obsVec(0);
      compared++;
      if (obs !== 31'd0) begin
         mismatched++;
         $display("[TB] FAIL midpress/after_reset: got %h expected 0", obs);
      end
      reset[0] = 1'b0;
      @(negedge clock);
      fillRandom(2);
      applyStimulus(0, 10, 0, 2, 1'b0, "midpress_reload");
   endtask

   task automatic test_idle_gap;
      resetDut(0);
      fillRandom(2);
      applyStimulus(0, 10, 100, 100, 1'b0, "idle_gap");
   endtask

   task automatic test_hold1;
      resetDut(1);
      fillRandom(5);
      applyStimulus(1, 1, 0, 2, 1'b0, "hold1");
   endtask

   task automatic test_random;
      for (int r = 0; r < 3; r++) begin
         resetDut(0);
         fillRandom(int'($urandom_range(4, 1)));
         applyStimulus(0, 10, 0, 5, 1'($urandom_range(1, 0)), "random");
      end
   endtask

   task automatic test_saturation;
      resetDut(1);
      fillRandom(4097);
      applyStimulus(1, 1, 0, 0, 1'b0, "saturate");
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         reset[d] = 1'b1; wordValid[d] = 1'b0; wordAddr[d] = '0;
         wordData[d] = '0; wordLast[d] = 1'b0; runLed[d] = 1'b0;
      end
      test_reset(0);
      test_reset(1);
      test_single_word();
      test_back_to_back();
      test_reset_mid_press();
      test_idle_gap();
      test_hold1();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/panel_load_sequencer.md
# panel_load_sequencer

Synthesizable controller that loads a program image into the PDP-8 through the Front_Panel switch/button interface, then starts execution. It accepts (address, data) words over a valid/ready stream. For each word it performs a Load-PC press followed by a Deposit press. After the last word it loads the start PC, raises the run switch and reports completion when the CPU halts. It sits between an image source (ROM, UART receiver or transactor) and Front_Panel, replacing bench-side button sequencing.

## Interface
- HOLD_CYCLES, 10, cycles per panel phase (switch setup, button press, button release); legal range ≥1
- START_PC, 12'o0200, PC loaded before run
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- word_valid  in  1  image word available
- word_ready  out  1  sequencer can accept a word
- word_addr  in  12  target memory address
- word_data  in  12  value to deposit
- word_last  in  1  final word of image
- sw  out  13  to Front_Panel switches; [11:0] data/address, [12] run switch
- load_pc_btn  out  1  to Front_Panel btnl
- deposit_btn  out  1  to Front_Panel btnd
- run_led  in  1  Front_Panel led[12]
- busy  out  1  load or run in progress
- done  out  1  program ran and halted; sticky until reset
- word_count  out  13  words deposited, 0..4096

## Operation
- States: ACCEPT, ADDR_SETUP, ADDR_PRESS, ADDR_RELEASE, DATA_SETUP, DATA_PRESS, DATA_RELEASE, PC_SETUP, PC_PRESS, PC_RELEASE, RUN_ARM, RUN_WAIT_HI, RUN_WAIT_LO, DONE.
- ACCEPT: word_ready=1. On word_valid&&word_ready, capture addr/data/last, then go to ADDR_SETUP. word_valid low holds ACCEPT indefinitely.
- ADDR_*: sw[11:0]=addr throughout. load_pc_btn=1 only in ADDR_PRESS.
- DATA_*: sw[11:0]=data throughout. deposit_btn=1 only in DATA_PRESS. word_count increments on exit of DATA_RELEASE.
- After DATA_RELEASE: go to ACCEPT if last=0, else PC_SETUP.
- Every load is preceded by its own Load-PC; panel auto-increment is never relied upon.
- PC_*: same as ADDR_* with sw[11:0]=START_PC.
- RUN_ARM: sw[11:0]=0, sw[12]=1 for HOLD_CYCLES, then RUN_WAIT_HI.
- RUN_WAIT_HI: wait for run_led=1. RUN_WAIT_LO: wait for run_led=0, then DONE.
- DONE: sw[12]=0, done=1, busy=0. Terminal until reset.
- busy=1 in every state except ACCEPT-with-word_count=0 and DONE.
- word_valid outside ACCEPT is ignored.

## Timing
- Reset values: sw=0, load_pc_btn=0, deposit_btn=0, word_ready=0, busy=0, done=0, word_count=0, state=ACCEPT.
- word_ready rises the first cycle after reset deasserts.
- Each phase state lasts exactly HOLD_CYCLES cycles, using a down-counter sized $clog2(HOLD_CYCLES+1) that reloads on every state entry.
- Per-word latency: handshake at cycle t; sw[11:0]=addr from t+1; load_pc_btn high t+1+H..t+2H; sw=data from t+1+3H; deposit_btn high t+1+4H..t+5H; word_ready high again at t+1+6H (H=10 gives 61).
- Buttons change only while sw is stable. sw never changes within H cycles of any button edge.
- word_count saturates at 4096. A 4097th word is still deposited but not counted.
- Reset mid-operation, including mid-press: all outputs take their reset values on the next clock edge and buttons drop immediately. No partial state is retained.
- run_led already high on entering RUN_WAIT_HI passes straight through.

## Structure
- CPU_Definitions.pkg: add typedef enum for the sequencer states. Reuse the existing `word` type for the 12-bit fields.
- One sub-module, panel_phase_timer: counter with load/expire for HOLD_CYCLES. It is instantiated once, and the FSM selects which button and switch value it drives.

## Test plan
- Reset held 5 cycles then released -> all outputs 0 during reset; word_ready=1 on the first cycle after release.
- One word addr=12'o0200, data=12'o7402, last=1, H=10:
  - sw[11:0]=0200 and load_pc_btn high cycles t+11..t+20.
  - deposit_btn high t+41..t+50 with sw=7402.
  - START_PC load follows, then sw[12]=1.
  - Bench pulses run_led 1 then 0 -> done=1, word_count=1, sw[12]=0.
- Three words (0200/7200, 0201/1000, 0202/7402), valid held high -> handshakes 61 cycles apart; word_count=3 before PC_SETUP.
- reset asserted during DATA_PRESS -> deposit_btn=0 and sw=0 the next cycle; word_count=0; a fresh image then loads normally.
- HOLD_CYCLES=1 -> word_ready returns 7 cycles after each handshake; every button pulse is exactly 1 cycle.
- word_valid deasserted for 100 cycles between words -> FSM stays in ACCEPT with buttons low; no spurious deposit.
